// File: rtl/spi_flash_xip_apb_if.sv
// APB completer-side bundle for the XIP flash window.
// Carries one APB access; no buffering in the interface itself.
// Backpressure is the completer's in_pready; the requester holds the access phase until it rises.
`timescale 1ns/1ps

interface spi_flash_xip_apb_if;
  logic [31:0] in_paddr;
  logic        in_psel;
  logic        in_penable;
  logic [2:0]  in_pprot;
  logic        in_pwrite;
  logic [31:0] in_pwdata;
  logic [3:0]  in_pstrb;
  logic        in_pready;
  logic [31:0] in_prdata;
  logic        in_pslverr;

  modport master (
    output in_paddr, in_psel, in_penable, in_pprot, in_pwrite, in_pwdata, in_pstrb,
    input  in_pready, in_prdata, in_pslverr
  );

  modport slave (
    input  in_paddr, in_psel, in_penable, in_pprot, in_pwrite, in_pwdata, in_pstrb,
    output in_pready, in_prdata, in_pslverr
  );
endinterface

// File: rtl/spi_flash_xip_apb.sv
// APB slave mapping a SPI NOR flash for execute-in-place word reads (cmd + addr + dummy + 32 data bits).
// Latency: 2*H*(8+ADDR_BITS+DUMMY_CYCLES+32) + CS_HOLD + 1 clocks per fetch; errors/buffer hits answer in 1.
// Backpressure: in_pready is held low for the whole SPI fetch; optional word buffer via SPI_XIP_WORDBUF_EN.
`timescale 1ns/1ps

module spi_flash_xip_apb #(
  parameter logic [31:0] FLASH_ADDR_START = 32'h3000_0000,
  parameter logic [31:0] FLASH_ADDR_END   = 32'h3fff_ffff,
  parameter int          SPI_SS_NUM       = 8,
  parameter int          FLASH_SS_IDX     = 0,
  parameter int          CLK_DIV          = 0,
  parameter int          ADDR_BITS        = 24,
  parameter logic [7:0]  READ_CMD         = 8'h03,
  parameter int          DUMMY_CYCLES     = 0,
  parameter int          CS_HOLD          = 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  spi_flash_xip_apb_if.slave    apb,
  output logic                  spi_sck,
  output logic [SPI_SS_NUM-1:0] spi_ss,
  output logic                  spi_mosi,
  input  logic                  spi_miso
);

  localparam int         TXW           = 8 + ADDR_BITS;
  localparam logic [7:0] LP_DIV        = 8'(CLK_DIV);
  localparam logic [5:0] LP_TX_LAST    = 6'(TXW - 1);
  localparam logic [5:0] LP_DUMMY_LAST = 6'((DUMMY_CYCLES > 0) ? (DUMMY_CYCLES - 1) : 0);
  localparam logic [5:0] LP_DATA_LAST  = 6'd31;
  localparam logic [7:0] LP_HOLD_LAST  = 8'(CS_HOLD - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SHIFT = 3'd1,
    S_DUMMY = 3'd2,
    S_DATA  = 3'd3,
    S_HOLD  = 3'd4,
    S_RESP  = 3'd5
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Bit timing: r_div counts clocks within a half period, r_phase is the current SCK level.
  logic [7:0]     r_div;
  logic           r_phase;
  logic [5:0]     r_bit;
  logic [7:0]     r_hold;
  logic [TXW-1:0] r_tx;
  logic [31:0]    r_rx;
  logic [31:0]    r_prdata;
  logic           r_err;
  logic           r_drop;

  logic                 w_access;
  logic                 w_in_range;
  logic                 w_bad;
  logic                 w_hit;
  logic                 w_active;
  logic                 w_busy;
  logic                 w_half_end;
  logic                 w_rise;
  logic                 w_bit_end;
  logic                 w_drop;
  logic                 w_fetch_done;
  logic [ADDR_BITS-1:0] w_addr;
  logic [31:0]          w_word;
  logic [31:0]          w_buf_dat;
  logic                 w_unused_ok;

  assign w_access     = apb.in_psel & apb.in_penable;
  assign w_in_range   = (apb.in_paddr >= FLASH_ADDR_START) && (apb.in_paddr <= FLASH_ADDR_END);
  assign w_bad        = apb.in_pwrite | ~w_in_range;
  assign w_active     = (r_state == S_SHIFT) || (r_state == S_DUMMY) || (r_state == S_DATA);
  assign w_busy       = w_active || (r_state == S_HOLD);
  assign w_half_end   = (r_div == LP_DIV);
  assign w_rise       = w_active & ~r_phase & w_half_end;
  assign w_bit_end    = w_active & r_phase & w_half_end;
  assign w_drop       = r_drop | ~apb.in_psel;
  assign w_fetch_done = (r_state == S_DATA) && w_bit_end && (r_bit == LP_DATA_LAST);
  // Upper address bits beyond ADDR_BITS wrap silently; the word is always aligned.
  assign w_addr       = {apb.in_paddr[ADDR_BITS-1:2], 2'b00};
  // First received byte is the lowest flash address and lands in the low byte.
  assign w_word       = {r_rx[7:0], r_rx[15:8], r_rx[23:16], r_rx[31:24]};
  assign w_unused_ok  = ^{apb.in_pprot, apb.in_pwdata, apb.in_pstrb};

`ifdef SPI_XIP_WORDBUF_EN
  logic [29:0] r_buf_tag;
  logic [31:0] r_buf_dat;
  logic        r_buf_vld;
  logic [29:0] r_req_tag;

  assign w_hit     = r_buf_vld && (r_buf_tag == apb.in_paddr[31:2]);
  assign w_buf_dat = r_buf_dat;

  // One-word buffer: reloaded by every finished fetch, invalidated by reset and error responses.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_buf_tag <= '0;
      r_buf_dat <= '0;
      r_buf_vld <= 1'b0;
      r_req_tag <= '0;
    end else begin
      if (r_state == S_IDLE && w_access) begin
        r_req_tag <= apb.in_paddr[31:2];
      end
      if (r_state == S_IDLE && w_access && w_bad) begin
        r_buf_vld <= 1'b0;
      end else if (w_fetch_done) begin
        r_buf_vld <= 1'b1;
        r_buf_tag <= r_req_tag;
        r_buf_dat <= w_word;
      end
    end
  end
`else
  assign w_hit     = 1'b0;
  assign w_buf_dat = '0;
`endif

  // State register.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and pin outputs; everything idles high/low unless a state claims it.
  always_comb begin
    w_state_nxt   = r_state;
    spi_ss        = '1;
    spi_sck       = 1'b0;
    spi_mosi      = 1'b1;
    apb.in_pready = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_access) begin
          if (w_bad || w_hit) begin
            w_state_nxt = S_RESP;
          end else begin
            w_state_nxt = S_SHIFT;
          end
        end
      end
      S_SHIFT: begin
        spi_ss[FLASH_SS_IDX] = 1'b0;
        spi_sck              = r_phase;
        spi_mosi             = r_tx[TXW-1];
        if (w_bit_end && r_bit == LP_TX_LAST) begin
          w_state_nxt = (DUMMY_CYCLES > 0) ? S_DUMMY : S_DATA;
        end
      end
      S_DUMMY: begin
        spi_ss[FLASH_SS_IDX] = 1'b0;
        spi_sck              = r_phase;
        if (w_bit_end && r_bit == LP_DUMMY_LAST) begin
          w_state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        spi_ss[FLASH_SS_IDX] = 1'b0;
        spi_sck              = r_phase;
        if (w_fetch_done) begin
          w_state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (r_hold == LP_HOLD_LAST) begin
          // An abandoned access still finishes its SPI frame but gets no response.
          w_state_nxt = w_drop ? S_IDLE : S_RESP;
        end
      end
      S_RESP: begin
        apb.in_pready = 1'b1;
        w_state_nxt   = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // SCK divider, bit counters, shift registers and the response registers.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_div    <= '0;
      r_phase  <= 1'b0;
      r_bit    <= '0;
      r_hold   <= '0;
      r_tx     <= '0;
      r_rx     <= '0;
      r_prdata <= '0;
      r_err    <= 1'b0;
      r_drop   <= 1'b0;
    end else begin
      if (w_active) begin
        if (w_half_end) begin
          r_div   <= '0;
          r_phase <= ~r_phase;
        end else begin
          r_div <= r_div + 8'd1;
        end
      end else begin
        r_div   <= '0;
        r_phase <= 1'b0;
      end

      if (w_bit_end) begin
        r_bit <= (w_state_nxt != r_state) ? 6'd0 : (r_bit + 6'd1);
      end else if (!w_active) begin
        r_bit <= '0;
      end

      // Next MOSI bit appears at the start of the following low phase.
      if (r_state == S_SHIFT && w_bit_end) begin
        r_tx <= {r_tx[TXW-2:0], 1'b1};
      end

      if (r_state == S_DATA && w_rise) begin
        r_rx <= {r_rx[30:0], spi_miso};
      end

      r_hold <= (r_state == S_HOLD) ? (r_hold + 8'd1) : 8'd0;

      if (w_busy && !apb.in_psel) begin
        r_drop <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          r_drop <= 1'b0;
          r_tx   <= {READ_CMD, w_addr};
          if (w_access) begin
            r_err    <= w_bad;
            r_prdata <= (!w_bad && w_hit) ? w_buf_dat : 32'd0;
          end
        end
        S_HOLD: begin
          if (r_hold == LP_HOLD_LAST && !w_drop) begin
            r_prdata <= w_word;
          end
        end
        S_RESP: begin
          r_err    <= 1'b0;
          r_prdata <= '0;
        end
        default: begin
        end
      endcase
    end
  end

  assign apb.in_prdata  = r_prdata;
  assign apb.in_pslverr = r_err;

endmodule
